// File: rtl/sorted_stream_unloader_if.sv
// Stream bundle for sorted_stream_unloader: sorted-vector capture side and key-per-beat output side.
// The slave modport is the unloader; the master modport is its surrounding producer/consumer.
interface sorted_stream_unloader_if #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned n     = 8
);
    localparam int unsigned KEYS = 2 * n;
    localparam int unsigned IW   = $clog2(KEYS);
    localparam int unsigned CW   = $clog2(KEYS) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [KEYS*WIDTH-1:0] c;
    logic [CW-1:0]         in_count;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IW-1:0]         out_idx;
    logic                  out_last;
    logic                  busy;

    modport slave (
        input  in_valid, c, in_count, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output in_valid, c, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/sorted_stream_unloader.sv
// Captures a sorted 2n-key vector and serialises it one key per beat on a valid/ready stream.
// Define SORTER_UNLOAD_DESC_EN to emit keys from the highest meaningful index down to 0.
module sorted_stream_unloader #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned n     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    sorted_stream_unloader_if.slave bus
);
    localparam int unsigned KEYS = 2 * n;
    localparam int unsigned IW   = $clog2(KEYS);
    localparam int unsigned CW   = $clog2(KEYS) + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                      state;
    logic [KEYS-1:0][WIDTH-1:0]  held;
    logic [KEYS-1:0][WIDTH-1:0]  c_keys;

    logic [CW-1:0] cnt_c;
    logic [IW-1:0] cnt_m1_c;
    logic [IW-1:0] first_idx_c;
    logic [IW-1:0] next_idx_c;
    logic          first_last_c;
    logic          next_last_c;

`ifndef SORTER_UNLOAD_DESC_EN
    logic [IW-1:0] last_idx;
`endif

    assign c_keys = bus.c;

    // Clamped key count, start position and next pointer step for the active emit order
    always_comb begin
        cnt_c        = (bus.in_count > CW'(KEYS)) ? CW'(KEYS) : bus.in_count;
        cnt_m1_c     = IW'(cnt_c - CW'(1));
        first_last_c = (cnt_c == CW'(1));
`ifdef SORTER_UNLOAD_DESC_EN
        first_idx_c  = cnt_m1_c;
        next_idx_c   = bus.out_idx - IW'(1);
        next_last_c  = (next_idx_c == '0);
`else
        first_idx_c  = '0;
        next_idx_c   = bus.out_idx + IW'(1);
        next_last_c  = (next_idx_c == last_idx);
`endif
    end

    // out_idx doubles as the read pointer; out_data is reloaded from the held vector on each step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            held          <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
`ifndef SORTER_UNLOAD_DESC_EN
            last_idx      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        held <= c_keys;
                        if (cnt_c != '0) begin
                            state         <= SEND;
                            bus.in_ready  <= 1'b0;
                            bus.busy      <= 1'b1;
                            bus.out_valid <= 1'b1;
                            bus.out_idx   <= first_idx_c;
                            bus.out_data  <= c_keys[first_idx_c];
                            bus.out_last  <= first_last_c;
`ifndef SORTER_UNLOAD_DESC_EN
                            last_idx      <= cnt_m1_c;
`endif
                        end
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (bus.out_last) begin
                            state         <= IDLE;
                            bus.in_ready  <= 1'b1;
                            bus.busy      <= 1'b0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end else begin
                            bus.out_idx  <= next_idx_c;
                            bus.out_data <= held[next_idx_c];
                            bus.out_last <= next_last_c;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
